wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback result (the output of writeBack_cycle) and results returned by a long-latency unit such as a multi-cycle mul/div. Long-unit results are buffered in a small FIFO. The pipeline has default priority. A starvation counter forces the buffer to drain by stalling the pipeline for one cycle. The block sits between writeBack_cycle and the register file write port.

---
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. buffered long-latency results.
// The pipeline wins by default, and a starvation counter forces one buffer drain with a stall.
module wb_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          RegWriteW,
   input  logic [4:0]                    WriteAddressW,
   input  logic [DATA_WIDTH-1:0]         RegInDataW,
   input  logic                          LongValid,
   input  logic [4:0]                    LongAddress,
   input  logic [DATA_WIDTH-1:0]         LongData,
   output logic                          LongReady,
   output logic                          StallW,
   output logic                          RegWriteD,
   output logic [4:0]                    WriteAddressD,
   output logic [DATA_WIDTH-1:0]         RegInDataD,
   output logic [$clog2(FIFO_DEPTH):0]   PendingCount
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

   logic [4:0]            addr_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic [StW-1:0]  starve_q, starve_d;

   logic                  full, empty, pipe_req, force_drain, push, pop;
   logic                  grant_valid;
   logic [4:0]            grant_addr;
   logic [DATA_WIDTH-1:0] grant_data;

   assign full        = (count_q == CntW'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   assign force_drain = (starve_q == StW'(STARVE_LIMIT)) && !empty;
   assign pipe_req    = RegWriteW && (WriteAddressW != 5'd0);

   // Readiness and stall look only at registered state so upstream never sees a comb loop.
   assign LongReady    = !full && !reset;
   assign StallW       = force_drain && !reset;
   assign PendingCount = count_q;

   // Results aimed at x0 are acknowledged but dropped.
   assign push = LongValid && LongReady && (LongAddress != 5'd0);

   always_comb begin
      grant_valid = 1'b0;
      grant_addr  = '0;
      grant_data  = '0;
      pop         = 1'b0;
      if (force_drain || (!pipe_req && !empty)) begin
         grant_valid = 1'b1;
         grant_addr  = addr_mem[rd_ptr_q];
         grant_data  = data_mem[rd_ptr_q];
         pop         = 1'b1;
      end else if (pipe_req) begin
         grant_valid = 1'b1;
         grant_addr  = WriteAddressW;
         grant_data  = RegInDataW;
      end
   end

   // Counts consecutive cycles a non-empty buffer loses to the pipeline.
   always_comb begin
      starve_d = starve_q;
      if (empty || pop) begin
         starve_d = '0;
      end else if (starve_q != StW'(STARVE_LIMIT)) begin
         starve_d = starve_q + StW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= LongAddress;
         data_mem[wr_ptr_q] <= LongData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         starve_q      <= '0;
         RegWriteD     <= 1'b0;
         WriteAddressD <= '0;
         RegInDataD    <= '0;
      end else begin
         starve_q  <= starve_d;
         RegWriteD <= grant_valid;
         if (grant_valid) begin
            WriteAddressD <= grant_addr;
            RegInDataD    <= grant_data;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter with hand-computed expectations,
// plus a hand-written mid-operation reset sequence.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteW;
   logic [4:0]  WriteAddressW;
   logic [31:0] RegInDataW;
   logic        LongValid;
   logic [4:0]  LongAddress;
   logic [31:0] LongData;
   logic        LongReady;
   logic        StallW;
   logic        RegWriteD;
   logic [4:0]  WriteAddressD;
   logic [31:0] RegInDataD;
   logic [1:0]  PendingCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DATA_WIDTH  (32),
      .FIFO_DEPTH  (2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .RegWriteW    (RegWriteW),
      .WriteAddressW(WriteAddressW),
      .RegInDataW   (RegInDataW),
      .LongValid    (LongValid),
      .LongAddress  (LongAddress),
      .LongData     (LongData),
      .LongReady    (LongReady),
      .StallW       (StallW),
      .RegWriteD    (RegWriteD),
      .WriteAddressD(WriteAddressD),
      .RegInDataD   (RegInDataD),
      .PendingCount (PendingCount)
   );

   // Inputs for one cycle; ready/stall expected before the edge, port/count after it.
   typedef struct {
      logic        rst;
      logic        rw;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        e_ready;
      logic        e_stall;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic e_ready, input logic e_stall, input logic e_we,
                      input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [1:0] e_cnt);
      vec_t v;
      v.rst = rst; v.rw = rw; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld;
      v.e_ready = e_ready; v.e_stall = e_stall; v.e_we = e_we;
      v.e_wa = e_wa; v.e_wd = e_wd; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      reset = rst; RegWriteW = rw; WriteAddressW = wa; RegInDataW = wd;
      LongValid = lv; LongAddress = la; LongData = ld;
   endtask

   initial begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      //  rst rw wa     wd            lv la      ld            rdy stl we wa      wd            cnt
      // reset
      add(1, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd0,  32'h0,        2'd0);
      // pipeline only
      add(0, 1, 5'd5, 32'h12345678, 0, 5'd0,  32'h0,        1, 0, 1, 5'd5,  32'h12345678, 2'd0);
      add(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 5'd5,  32'h12345678, 2'd0);
      // long result with idle pipeline
      add(0, 0, 5'd0, 32'h0,        1, 5'd7,  32'hABCD1234, 1, 0, 0, 5'd5,  32'h12345678, 2'd1);
      add(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 1, 5'd7,  32'hABCD1234, 2'd0);
      add(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 5'd7,  32'hABCD1234, 2'd0);
      // x0 filtering on both sources
      add(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0,  32'h55555555, 1, 0, 0, 5'd7,  32'hABCD1234, 2'd0);
      // starvation: one entry, then four pipeline wins, then a forced drain
      add(0, 0, 5'd0, 32'h0,        1, 5'd9,  32'hDEADBEEF, 1, 0, 0, 5'd7,  32'hABCD1234, 2'd1);
      add(0, 1, 5'd3, 32'h33333333, 0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h33333333, 2'd1);
      add(0, 1, 5'd3, 32'h33333333, 0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h33333333, 2'd1);
      add(0, 1, 5'd3, 32'h33333333, 0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h33333333, 2'd1);
      add(0, 1, 5'd3, 32'h33333333, 0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h33333333, 2'd1);
      add(0, 1, 5'd3, 32'h33333333, 0, 5'd0,  32'h0,        1, 1, 1, 5'd9,  32'hDEADBEEF, 2'd0);
      add(0, 1, 5'd3, 32'h33333333, 0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h33333333, 2'd0);
      // full buffer while the pipeline writes every cycle
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd10, 32'hA0A0A0A0, 1, 0, 1, 5'd4,  32'h44444444, 2'd1);
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd11, 32'hB0B0B0B0, 1, 0, 1, 5'd4,  32'h44444444, 2'd2);
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd12, 32'hC0C0C0C0, 0, 0, 1, 5'd4,  32'h44444444, 2'd2);
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd12, 32'hC0C0C0C0, 0, 0, 1, 5'd4,  32'h44444444, 2'd2);
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd12, 32'hC0C0C0C0, 0, 0, 1, 5'd4,  32'h44444444, 2'd2);
      // forced drain while full: the pop does not open the push
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd12, 32'hC0C0C0C0, 0, 1, 1, 5'd10, 32'hA0A0A0A0, 2'd1);
      add(0, 1, 5'd4, 32'h44444444, 1, 5'd12, 32'hC0C0C0C0, 1, 0, 1, 5'd4,  32'h44444444, 2'd2);
      // drain in push order
      add(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 0, 1, 5'd11, 32'hB0B0B0B0, 2'd1);
      add(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 1, 5'd12, 32'hC0C0C0C0, 2'd0);
      add(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 5'd12, 32'hC0C0C0C0, 2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].rw, vecs[i].wa, vecs[i].wd,
               vecs[i].lv, vecs[i].la, vecs[i].ld);
         #1;
         chk($sformatf("v%0d LongReady", i), {31'd0, LongReady}, {31'd0, vecs[i].e_ready});
         chk($sformatf("v%0d StallW", i), {31'd0, StallW}, {31'd0, vecs[i].e_stall});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d RegWriteD", i), {31'd0, RegWriteD}, {31'd0, vecs[i].e_we});
         chk($sformatf("v%0d WriteAddressD", i), {27'd0, WriteAddressD}, {27'd0, vecs[i].e_wa});
         chk($sformatf("v%0d RegInDataD", i), RegInDataD, vecs[i].e_wd);
         chk($sformatf("v%0d PendingCount", i), {30'd0, PendingCount}, {30'd0, vecs[i].e_cnt});
      end

      // Reset mid-operation: two pending entries and starve at 3.
      drive(0, 1, 5'd4, 32'h44444444, 1, 5'd13, 32'h13131313);
      @(posedge clk); #1;
      drive(0, 1, 5'd4, 32'h44444444, 1, 5'd14, 32'h14141414);
      @(posedge clk); #1;
      drive(0, 1, 5'd4, 32'h44444444, 0, 5'd0, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre-reset PendingCount", {30'd0, PendingCount}, 32'd2);
      chk("pre-reset StallW", {31'd0, StallW}, 32'd0);
      drive(1, 1, 5'd4, 32'h44444444, 1, 5'd15, 32'h15151515);
      #1;
      chk("in-reset LongReady", {31'd0, LongReady}, 32'd0);
      chk("in-reset StallW", {31'd0, StallW}, 32'd0);
      @(posedge clk); #1;
      chk("post-reset PendingCount", {30'd0, PendingCount}, 32'd0);
      chk("post-reset RegWriteD", {31'd0, RegWriteD}, 32'd0);
      chk("post-reset WriteAddressD", {27'd0, WriteAddressD}, 32'd0);
      chk("post-reset RegInDataD", RegInDataD, 32'd0);
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("released %0d LongReady", k), {31'd0, LongReady}, 32'd1);
         chk($sformatf("released %0d StallW", k), {31'd0, StallW}, 32'd0);
         @(posedge clk); #1;
         chk($sformatf("released %0d RegWriteD", k), {31'd0, RegWriteD}, 32'd0);
         chk($sformatf("released %0d PendingCount", k), {30'd0, PendingCount}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
